// File: rtl/my_pkg.sv
// Shared fetch-stage types: instruction source select and the IMEM fetch controller states.
package my_pkg;

    typedef enum logic {
        NOP  = 1'b0,
        IMEM = 1'b1
    } FSM_Control_Enum;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BOOT = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        ERR  = 3'd4
    } imem_fetch_state_e;

endpackage

// File: rtl/fetch_down_counter.sv
// Saturating down counter with synchronous load, decrement and global enable.
module fetch_down_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (load_i) begin
                cnt_q <= load_val_i;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_q <= cnt_q - One;
            end
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch sequencer: boot NOPs, one-outstanding req/gnt/rvalid
// transactions at the current PC, redirect squashing and timeout trapping.
module imem_fetch_ctrl
    import my_pkg::*;
#(
    parameter int unsigned BOOT_NOPS = 4,
    parameter int unsigned MAX_WAIT  = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            EN,
    input  logic            START,
    input  logic [31:0]     PC,
    input  logic            PC_Changed,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    output FSM_Control_Enum FSM_SEL,
    output logic            fetch_stall,
    output logic            instr_valid,
    output logic            fetch_err
);

    localparam bit               BootSkip = (BOOT_NOPS == 0);
    localparam logic [CNT_W-1:0] BootLoad = BootSkip ? '0 : CNT_W'(BOOT_NOPS - 1);
    localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(MAX_WAIT - 1);

    imem_fetch_state_e state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic              squash_q, squash_d;
    logic              reload_q, reload_d;
    logic              err_q, err_d;

    logic              boot_load, boot_dec, boot_zero;
    logic              wait_load, wait_dec, wait_zero;
    logic [CNT_W-1:0]  unused_boot_cnt, unused_wait_cnt;
    logic              accept;
    logic [31:0]       pc_word;
    logic              unused_pc_lsb;

    assign pc_word       = {PC[31:2], 2'b00};
    assign unused_pc_lsb = ^PC[1:0];

    fetch_down_counter #(
        .CNT_W(CNT_W)
    ) u_boot_cnt (
        .clk_i     (CLK),
        .rst_ni    (RSTn),
        .en_i      (EN),
        .load_i    (boot_load),
        .load_val_i(BootLoad),
        .dec_i     (boot_dec),
        .count_o   (unused_boot_cnt),
        .zero_o    (boot_zero)
    );

    fetch_down_counter #(
        .CNT_W(CNT_W)
    ) u_wait_cnt (
        .clk_i     (CLK),
        .rst_ni    (RSTn),
        .en_i      (EN),
        .load_i    (wait_load),
        .load_val_i(WaitLoad),
        .dec_i     (wait_dec),
        .count_o   (unused_wait_cnt),
        .zero_o    (wait_zero)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        squash_d  = squash_q;
        reload_d  = reload_q;
        err_d     = err_q;
        boot_load = 1'b0;
        boot_dec  = 1'b0;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        accept    = 1'b0;

        if (EN) begin
            unique case (state_q)
                IDLE, ERR: begin
                    if (START) begin
                        err_d = 1'b0;
                        if (BootSkip) begin
                            state_d  = REQ;
                            addr_d   = pc_word;
                            reload_d = 1'b0;
                        end else begin
                            state_d   = BOOT;
                            boot_load = 1'b1;
                        end
                    end
                end
                BOOT: begin
                    if (boot_zero) begin
                        state_d  = REQ;
                        addr_d   = pc_word;
                        reload_d = 1'b0;
                    end else begin
                        boot_dec = 1'b1;
                    end
                end
                REQ: begin
                    // reload_q marks the one req-low cycle used to pick up a redirected PC
                    if (reload_q) begin
                        addr_d   = pc_word;
                        reload_d = PC_Changed;
                    end else if (imem_gnt) begin
                        state_d   = WAIT;
                        wait_load = 1'b1;
                        squash_d  = PC_Changed;
                    end else if (PC_Changed) begin
                        reload_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d  = REQ;
                        squash_d = 1'b0;
                        if (!squash_q && !PC_Changed) begin
                            accept = 1'b1;
                            // PC steps to the next word on this edge; prefetch that address
                            addr_d = pc_word + 32'd4;
                        end else begin
                            addr_d = pc_word;
                        end
                    end else begin
                        if (PC_Changed) begin
                            squash_d = 1'b1;
                        end
                        if (wait_zero) begin
                            state_d  = ERR;
                            err_d    = 1'b1;
                            squash_d = 1'b0;
                        end else begin
                            wait_dec = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            squash_q <= 1'b0;
            reload_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            squash_q <= squash_d;
            reload_q <= reload_d;
            err_q    <= err_d;
        end
    end

    assign imem_req    = (state_q == REQ) && !reload_q;
    assign imem_addr   = addr_q;
    assign FSM_SEL     = accept ? IMEM : NOP;
    assign instr_valid = accept;
    assign fetch_stall = !accept;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with an expected-address scoreboard.
module tb_imem_fetch_ctrl;
    import my_pkg::*;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic            EN;
    logic            START;
    logic [31:0]     PC;
    logic            PC_Changed;
    logic            imem_req;
    logic [31:0]     imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    FSM_Control_Enum FSM_SEL;
    logic            fetch_stall;
    logic            instr_valid;
    logic            fetch_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_addr_q[$];

    always #5 CLK = ~CLK;

    imem_fetch_ctrl #(
        .BOOT_NOPS(4),
        .MAX_WAIT (16),
        .CNT_W    (5)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .EN         (EN),
        .START      (START),
        .PC         (PC),
        .PC_Changed (PC_Changed),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .FSM_SEL    (FSM_SEL),
        .fetch_stall(fetch_stall),
        .instr_valid(instr_valid),
        .fetch_err  (fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        settle();
        tick();
        START = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        settle();
        while (!imem_req && n < 20) begin
            tick();
            settle();
            n++;
        end
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    endtask

    task automatic do_grant(input string tag);
        logic [31:0] e;
        wait_req(tag);
        e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hdead_beef;
        chk({tag, "_addr"}, imem_addr, e);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
    endtask

    task automatic do_rvalid(input string tag, input logic exp_acc);
        imem_rvalid = 1'b1;
        settle();
        chk({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, exp_acc});
        chk({tag, "_sel"}, 32'(FSM_SEL), exp_acc ? 32'(IMEM) : 32'(NOP));
        chk({tag, "_stall"}, {31'b0, fetch_stall}, {31'b0, !exp_acc});
        tick();
        imem_rvalid = 1'b0;
        if (exp_acc) PC = PC + 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic bad;

        RSTn        = 1'b0;
        EN          = 1'b1;
        START       = 1'b0;
        PC          = 32'h0;
        PC_Changed  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'd0);
        chk("rst_sel",   32'(FSM_SEL),         32'(NOP));
        chk("rst_stall", {31'b0, fetch_stall}, 32'd1);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_err",   {31'b0, fetch_err},   32'd0);
        RSTn = 1'b1;
        tick();
        tick();

        // Boot: exactly four NOP cycles, then a request at PC=0
        exp_addr_q.push_back(32'h0);
        pulse_start();
        n   = 0;
        bad = 1'b0;
        settle();
        while (!imem_req && n < 20) begin
            if (FSM_SEL !== NOP || fetch_stall !== 1'b1) bad = 1'b1;
            n++;
            tick();
            settle();
        end
        chk("boot_nops", 32'(n), 32'd4);
        chk("boot_nop_outputs", {31'b0, bad}, 32'd0);
        chk("boot_addr", imem_addr, exp_addr_q.pop_front());

        // Redirect while requesting without grant: req drops for a cycle
        PC         = 32'h100;
        PC_Changed = 1'b1;
        exp_addr_q.push_back(32'h100);
        tick();
        PC_Changed = 1'b0;
        settle();
        chk("redir_req_drop", {31'b0, imem_req}, 32'd0);
        tick();

        // Nominal fetch at 0x100, next request at 0x104
        do_grant("nom");
        do_rvalid("nom", 1'b1);
        exp_addr_q.push_back(PC);
        do_grant("seq");

        // Redirect while waiting: the response is dropped
        PC         = 32'h200;
        PC_Changed = 1'b1;
        exp_addr_q.push_back(32'h200);
        settle();
        chk("wait_stall", {31'b0, fetch_stall}, 32'd1);
        tick();
        PC_Changed = 1'b0;
        tick();
        do_rvalid("squash", 1'b0);
        do_grant("redir");

        // rvalid together with PC_Changed
        PC         = 32'h300;
        PC_Changed = 1'b1;
        exp_addr_q.push_back(32'h300);
        do_rvalid("simul", 1'b0);
        PC_Changed = 1'b0;
        do_grant("simul");

        // Timeout: no rvalid for MAX_WAIT cycles after grant
        n = 0;
        settle();
        while (!fetch_err && n < 40) begin
            tick();
            settle();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("err_stall", {31'b0, fetch_stall}, 32'd1);
        chk("err_req", {31'b0, imem_req}, 32'd0);
        tick();
        tick();
        settle();
        chk("err_sticky", {31'b0, fetch_err}, 32'd1);

        // Restart from ERR, with EN low for 3 cycles while the boot count is 2
        pulse_start();
        settle();
        chk("restart_err_clr", {31'b0, fetch_err}, 32'd0);
        tick();
        EN  = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_stall !== 1'b1) bad = 1'b1;
            tick();
        end
        chk("en_low_outputs", {31'b0, bad}, 32'd0);
        EN = 1'b1;
        n  = 1;
        settle();
        while (!imem_req && n < 20) begin
            n++;
            tick();
            settle();
        end
        chk("en_boot_nops", 32'(n), 32'd4);
        exp_addr_q.push_back(PC);
        do_grant("reboot");
        tick();
        do_rvalid("late_ok", 1'b1);
        exp_addr_q.push_back(PC);
        do_grant("after");

        // Reset mid-transaction, then a late rvalid is ignored
        RSTn = 1'b0;
        settle();
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        tick();
        RSTn = 1'b1;
        do_rvalid("post_rst", 1'b0);
        settle();
        chk("post_rst_idle", {31'b0, imem_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
